control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/channel_pkg.sv | 45 ++++
 rtl/cu_select_pass.sv | 14 +
 rtl/control_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_control_unit.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/channel_pkg.sv
// Shared channel definitions: status bits, command codes and control-unit states.
// CU_SHORT_BUSY_EN adds the SHORT_BUSY state for the short busy response.
package channel_pkg;

    localparam logic [7:0] ATTN = 8'h80;
    localparam logic [7:0] SM   = 8'h40;
    localparam logic [7:0] CUE  = 8'h20;
    localparam logic [7:0] BUSY = 8'h10;
    localparam logic [7:0] CE   = 8'h08;
    localparam logic [7:0] DE   = 8'h04;
    localparam logic [7:0] UC   = 8'h02;
    localparam logic [7:0] UE   = 8'h01;

    localparam logic [7:0] WRITE = 8'h01;
    localparam logic [7:0] READ  = 8'h02;
    localparam logic [7:0] NOP   = 8'h03;

    typedef enum logic [3:0] {
        IDLE,
        PASS,
        ADDR,
        CMD,
        INIT_ST,
        DATA_REQ,
        DATA_ACK,
        END_ST,
        WAIT_DESEL
`ifdef CU_SHORT_BUSY_EN
        , SHORT_BUSY
`endif
    } cu_state_t;

    // Initial status presented after the command byte has been accepted.
    function automatic logic [7:0] initial_status(input logic busy, input logic [7:0] code);
        if (busy)
            return BUSY;
        else if (code == WRITE || code == READ)
            return 8'h00;
        else if (code == NOP)
            return CE | DE;
        else
            return UC | CE | DE;
    endfunction

endpackage

// File: rtl/cu_select_pass.sv
// Select propagation: passes the select down the chain and returns it while
// the control unit is not the addressed device.
module cu_select_pass (
    input  logic pass_en,
    input  logic a_select_out,
    input  logic b_select_in,
    output logic b_select_out,
    output logic a_select_in
);

    assign b_select_out = pass_en & a_select_out;
    assign a_select_in  = pass_en & b_select_in;

endmodule

// File: rtl/control_unit.sv
// Channel control unit: selection, command, initial/ending status and byte transfer.
// Define CU_SHORT_BUSY_EN to answer a busy selection with a short busy status.
module control_unit
    import channel_pkg::*;
#(
    parameter logic [7:0] ADDRESS = 8'h1a
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] bus_out,
    output logic [7:0] bus_in,
    input  logic       operational_out,
    input  logic       hold_out,
    input  logic       address_out,
    input  logic       command_out,
    input  logic       service_out,
    input  logic       suppress_out,
    input  logic       a_select_out,
    output logic       a_select_in,
    output logic       b_select_out,
    input  logic       b_select_in,
    output logic       operational_in,
    output logic       address_in,
    output logic       status_in,
    output logic       service_in,
    output logic       request_in,
    input  logic       dev_busy,
    input  logic [7:0] rd_data,
    input  logic       rd_valid,
    input  logic       rd_last,
    output logic       rd_ack,
    output logic [7:0] wr_data,
    output logic       wr_strobe,
    input  logic       wr_ready,
    input  logic       wr_end,
    output logic [7:0] cmd,
    output logic       cmd_strobe
);

    cu_state_t  state, state_next;
    logic [7:0] status_q;
    logic [7:0] data_q;
    logic       last_q;
    logic       svc_up;
    logic       stat_ack;
    logic       stop_pend;
    logic       pass_en;
    logic       is_read;
    logic       unused_tags;

    assign is_read     = (cmd == READ);
    assign request_in  = 1'b0;
    assign unused_tags = suppress_out;

    cu_select_pass u_select_pass (
        .pass_en      (pass_en),
        .a_select_out (a_select_out),
        .b_select_in  (b_select_in),
        .b_select_out (b_select_out),
        .a_select_in  (a_select_in)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:
                if (a_select_out && address_out) begin
                    if (bus_out == ADDRESS) begin
`ifdef CU_SHORT_BUSY_EN
                        state_next = dev_busy ? SHORT_BUSY : ADDR;
`else
                        state_next = ADDR;
`endif
                    end else begin
                        state_next = PASS;
                    end
                end
            PASS:
                if (!a_select_out) state_next = IDLE;
            ADDR:
                if (!address_out && command_out) state_next = CMD;
            CMD:
                if (!command_out) state_next = INIT_ST;
            INIT_ST:
                if (stat_ack && !service_out)
                    state_next = (status_q == 8'h00) ? DATA_REQ : WAIT_DESEL;
            DATA_REQ:
                // A channel stop waits for command_out to fall before ending status.
                if (stop_pend) begin
                    if (!command_out) state_next = END_ST;
                end else if (svc_up) begin
                    if (service_out) state_next = DATA_ACK;
                end else if (!is_read && wr_end) begin
                    state_next = END_ST;
                end
            DATA_ACK:
                if (!service_out)
                    state_next = (is_read && last_q) ? END_ST : DATA_REQ;
            END_ST:
                if (stat_ack && !service_out) state_next = WAIT_DESEL;
`ifdef CU_SHORT_BUSY_EN
            SHORT_BUSY:
                if (stat_ack && !service_out) state_next = WAIT_DESEL;
`endif
            WAIT_DESEL:
                if (!a_select_out && !hold_out) state_next = IDLE;
            default:
                state_next = IDLE;
        endcase
        if (!operational_out) state_next = IDLE;
    end

    always_comb begin
        operational_in = 1'b0;
        address_in     = 1'b0;
        status_in      = 1'b0;
        service_in     = 1'b0;
        bus_in         = '0;
        pass_en        = 1'b0;
        case (state)
            PASS:
                pass_en = 1'b1;
            ADDR: begin
                operational_in = 1'b1;
                address_in     = 1'b1;
                bus_in         = ADDRESS;
            end
            CMD:
                operational_in = 1'b1;
            INIT_ST: begin
                operational_in = 1'b1;
                status_in      = !stat_ack;
                if (!stat_ack) bus_in = status_q;
            end
            DATA_REQ: begin
                operational_in = 1'b1;
                service_in     = svc_up;
                if (svc_up && is_read) bus_in = data_q;
            end
            DATA_ACK:
                operational_in = 1'b1;
            END_ST: begin
                operational_in = 1'b1;
                status_in      = !stat_ack;
                if (!stat_ack) bus_in = CE | DE;
            end
`ifdef CU_SHORT_BUSY_EN
            SHORT_BUSY: begin
                status_in = !stat_ack;
                if (!stat_ack) bus_in = SM | BUSY;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_q   <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            svc_up     <= 1'b0;
            stat_ack   <= 1'b0;
            stop_pend  <= 1'b0;
            rd_ack     <= 1'b0;
            wr_strobe  <= 1'b0;
            cmd_strobe <= 1'b0;
            cmd        <= '0;
            wr_data    <= '0;
        end else begin
            rd_ack     <= 1'b0;
            wr_strobe  <= 1'b0;
            cmd_strobe <= 1'b0;
            // Handshake flags are per-state and restart on every state change.
            if (state_next != state) begin
                svc_up    <= 1'b0;
                stat_ack  <= 1'b0;
                stop_pend <= 1'b0;
            end else begin
                case (state)
                    INIT_ST, END_ST:
                        if (service_out) stat_ack <= 1'b1;
`ifdef CU_SHORT_BUSY_EN
                    SHORT_BUSY:
                        if (service_out) stat_ack <= 1'b1;
`endif
                    DATA_REQ:
                        if (!svc_up) begin
                            if (!stop_pend) begin
                                if (is_read && rd_valid) begin
                                    svc_up <= 1'b1;
                                    data_q <= rd_data;
                                    last_q <= rd_last;
                                end else if (!is_read && wr_ready && !wr_end) begin
                                    svc_up <= 1'b1;
                                end
                            end
                        end else if (command_out && !service_out) begin
                            svc_up    <= 1'b0;
                            stop_pend <= 1'b1;
                        end
                    default: ;
                endcase
            end
            if (state == ADDR && state_next == CMD) begin
                cmd        <= bus_out;
                cmd_strobe <= 1'b1;
            end
            if (state == CMD && state_next == INIT_ST)
                status_q <= initial_status(dev_busy, cmd);
            if (state == DATA_REQ && state_next == DATA_ACK) begin
                if (is_read) begin
                    rd_ack <= 1'b1;
                end else begin
                    wr_data   <= bus_out;
                    wr_strobe <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a channel-side driver, a read source and
// write sink, with expectations derived from the channel protocol rules.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] bus_out, bus_in;
    logic       operational_out, hold_out, address_out, command_out, service_out, suppress_out;
    logic       a_select_out, a_select_in, b_select_out, b_select_in;
    logic       operational_in, address_in, status_in, service_in, request_in;
    logic       dev_busy;
    logic [7:0] rd_data;
    logic       rd_valid, rd_last, rd_ack;
    logic [7:0] wr_data;
    logic       wr_strobe, wr_ready, wr_end;
    logic [7:0] cmd;
    logic       cmd_strobe;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    control_unit #(.ADDRESS(8'h1a)) dut (
        .clk(clk), .reset(reset), .bus_out(bus_out), .bus_in(bus_in),
        .operational_out(operational_out), .hold_out(hold_out), .address_out(address_out),
        .command_out(command_out), .service_out(service_out), .suppress_out(suppress_out),
        .a_select_out(a_select_out), .a_select_in(a_select_in),
        .b_select_out(b_select_out), .b_select_in(b_select_in),
        .operational_in(operational_in), .address_in(address_in), .status_in(status_in),
        .service_in(service_in), .request_in(request_in), .dev_busy(dev_busy),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ack(rd_ack),
        .wr_data(wr_data), .wr_strobe(wr_strobe), .wr_ready(wr_ready), .wr_end(wr_end),
        .cmd(cmd), .cmd_strobe(cmd_strobe)
    );

    // Read source: a list of queued bytes, consumed one per rd_ack pulse.
    logic [7:0] rd_mem [0:15];
    int rd_n = 0, rd_base = 0, rd_ack_cnt = 0, rd_idx;
    assign rd_idx   = rd_ack_cnt - rd_base;
    assign rd_valid = (rd_idx < rd_n);
    assign rd_data  = rd_valid ? rd_mem[rd_idx[3:0]] : 8'h00;
    assign rd_last  = rd_valid && (rd_idx == rd_n - 1);

    // Write sink: logs strobed bytes, raises wr_end after wr_limit bytes.
    logic [7:0] wr_log [0:63];
    int wr_cnt = 0, wr_base = 0, wr_limit = 1000;
    assign wr_end = ((wr_cnt - wr_base) >= wr_limit);

    int cmd_cnt = 0, op_cnt = 0;

    always @(negedge clk) begin
        if (rd_ack) rd_ack_cnt <= rd_ack_cnt + 1;
        if (wr_strobe) begin
            wr_log[wr_cnt[5:0]] <= wr_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (cmd_strobe) cmd_cnt <= cmd_cnt + 1;
        if (operational_in) op_cnt <= op_cnt + 1;
    end

    // Channel side state shared with the scenario tasks.
    logic [7:0] chan_wdata [0:15];
    logic [7:0] rx [0:15];
    int         rx_n;
    logic [7:0] echo;
    logic [3:0] abort_tags;

    function automatic bit cond(input int c);
        case (c)
            0: return address_in;
            1: return !address_in;
            2: return status_in;
            3: return !status_in;
            4: return service_in;
            5: return !service_in;
            6: return service_in || status_in;
            7: return address_in || status_in;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_cond(input int c, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cond(c)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // One complete selection from the channel side.
    task automatic run_sel(input logic [7:0] addr, input logic [7:0] code, input int chan_count,
                           input int stop_at, input int abort_at, output bit ok,
                           output logic [7:0] init_st, output logic [7:0] end_st);
        bit w;
        bit aborted;
        ok = 1'b1; aborted = 1'b0; init_st = 8'hxx; end_st = 8'hxx; rx_n = 0; echo = 8'hxx;
        bus_out = addr; a_select_out = 1'b1; address_out = 1'b1;
        @(negedge clk);
        wait_cond(7, w); ok &= w;
        if (w && status_in) begin
            init_st = bus_in; service_out = 1'b1;
            wait_cond(3, w); ok &= w;
            service_out = 1'b0;
        end else if (w) begin
            echo = bus_in;
            address_out = 1'b0; command_out = 1'b1; bus_out = code;
            wait_cond(1, w); ok &= w;
            command_out = 1'b0; bus_out = 8'h00;
            wait_cond(2, w); ok &= w;
            init_st = bus_in; service_out = 1'b1;
            wait_cond(3, w); ok &= w;
            service_out = 1'b0;
            if (init_st == 8'h00) begin
                for (int i = 0; i < chan_count && ok; i++) begin
                    wait_cond(6, w); ok &= w;
                    if (!w || status_in) break;
                    if (i == abort_at) begin
                        operational_out = 1'b0; a_select_out = 1'b0;
                        @(negedge clk);
                        abort_tags = {operational_in, address_in, status_in, service_in};
                        operational_out = 1'b1;
                        aborted = 1'b1;
                        break;
                    end
                    if (i == stop_at) begin
                        command_out = 1'b1;
                        wait_cond(5, w); ok &= w;
                        command_out = 1'b0;
                        break;
                    end
                    rx[rx_n[3:0]] = bus_in; rx_n++;
                    bus_out = chan_wdata[i]; service_out = 1'b1;
                    wait_cond(5, w); ok &= w;
                    service_out = 1'b0; bus_out = 8'h00;
                end
                if (!aborted) begin
                    wait_cond(2, w); ok &= w;
                    end_st = bus_in; service_out = 1'b1;
                    wait_cond(3, w); ok &= w;
                    service_out = 1'b0;
                end
            end
        end
        address_out = 1'b0; a_select_out = 1'b0; bus_out = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus_out = 8'h00; operational_out = 1'b1; hold_out = 1'b0; address_out = 1'b0;
        command_out = 1'b0; service_out = 1'b0; suppress_out = 1'b0; a_select_out = 1'b0;
        b_select_in = 1'b0; dev_busy = 1'b0; wr_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({operational_in, address_in, status_in, service_in, request_in, a_select_in,
             b_select_out, rd_ack, wr_strobe, cmd_strobe} !== 10'b0) begin
            errors++;
            $display("FAIL reset_tags: got %b want 0", {operational_in, address_in, status_in,
                     service_in, request_in, a_select_in, b_select_out, rd_ack, wr_strobe, cmd_strobe});
        end
        checks++;
        if ({bus_in, cmd, wr_data} !== 24'h0) begin
            errors++;
            $display("FAIL reset_buses: got %h want 000000", {bus_in, cmd, wr_data});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_pass;
        logic [7:0] addr;
        int c0, o0;
        addr = 8'($urandom);
        while (addr == 8'h1a) addr = 8'($urandom);
        c0 = cmd_cnt; o0 = op_cnt;
        bus_out = addr; a_select_out = 1'b1; address_out = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            b_select_in = 1'($urandom);
            #1;
            checks++;
            if ({b_select_out, a_select_in, operational_in} !== {1'b1, b_select_in, 1'b0}) begin
                errors++;
                $display("FAIL pass_follow: got %b want %b", {b_select_out, a_select_in, operational_in},
                         {1'b1, b_select_in, 1'b0});
            end
            @(negedge clk);
        end
        a_select_out = 1'b0; address_out = 1'b0; b_select_in = 1'b0;
        @(negedge clk);
        checks++;
        if (b_select_out !== 1'b0) begin
            errors++;
            $display("FAIL pass_release: got %b want 0", b_select_out);
        end
        checks++;
        if ((cmd_cnt - c0) !== 0 || (op_cnt - o0) !== 0) begin
            errors++;
            $display("FAIL pass_quiet: got cmd_strobes=%0d op_cycles=%0d want 0 0", cmd_cnt - c0, op_cnt - o0);
        end
    endtask

    task automatic test_read;
        bit ok; logic [7:0] ist, est; int a0, c0;
        for (int i = 0; i < 4; i++) rd_mem[i] = 8'($urandom);
        rd_base = rd_ack_cnt; rd_n = 4; a0 = rd_ack_cnt; c0 = cmd_cnt;
        run_sel(8'h1a, 8'h02, 6, -1, -1, ok, ist, est);
        checks++;
        if ({ok, echo, ist, est} !== {1'b1, 8'h1a, 8'h00, 8'h0c}) begin
            errors++;
            $display("FAIL read_status: got ok=%b echo=%h init=%h end=%h want 1 1a 00 0c", ok, echo, ist, est);
        end
        checks++;
        if ((rd_ack_cnt - a0) !== 4 || rx_n !== 4) begin
            errors++;
            $display("FAIL read_count: got acks=%0d bytes=%0d want 4 4", rd_ack_cnt - a0, rx_n);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx[i] !== rd_mem[i]) begin
                errors++;
                $display("FAIL read_byte%0d: got %h want %h", i, rx[i], rd_mem[i]);
            end
        end
        checks++;
        if ({cmd, 32'(cmd_cnt - c0), operational_in} !== {8'h02, 32'd1, 1'b0}) begin
            errors++;
            $display("FAIL read_cmd: got cmd=%h strobes=%0d op=%b want 02 1 0", cmd, cmd_cnt - c0, operational_in);
        end
    endtask

    task automatic test_write;
        bit ok; logic [7:0] ist, est;
        for (int i = 0; i < 6; i++) chan_wdata[i] = 8'($urandom);
        wr_base = wr_cnt; wr_limit = 3;
        run_sel(8'h1a, 8'h01, 6, -1, -1, ok, ist, est);
        checks++;
        if ({ok, ist, est} !== {1'b1, 8'h00, 8'h0c}) begin
            errors++;
            $display("FAIL write_status: got ok=%b init=%h end=%h want 1 00 0c", ok, ist, est);
        end
        checks++;
        if ((wr_cnt - wr_base) !== 3) begin
            errors++;
            $display("FAIL write_count: got %0d want 3", wr_cnt - wr_base);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wr_log[6'(wr_base + i)] !== chan_wdata[i]) begin
                errors++;
                $display("FAIL write_byte%0d: got %h want %h", i, wr_log[6'(wr_base + i)], chan_wdata[i]);
            end
        end
        wr_limit = 1000;
    endtask

    task automatic test_stop;
        bit ok; logic [7:0] ist, est; int a0;
        for (int i = 0; i < 6; i++) rd_mem[i] = 8'($urandom);
        rd_base = rd_ack_cnt; rd_n = 6; a0 = rd_ack_cnt;
        run_sel(8'h1a, 8'h02, 6, 2, -1, ok, ist, est);
        checks++;
        if ({ok, ist, est} !== {1'b1, 8'h00, 8'h0c}) begin
            errors++;
            $display("FAIL stop_status: got ok=%b init=%h end=%h want 1 00 0c", ok, ist, est);
        end
        checks++;
        if ((rd_ack_cnt - a0) !== 2 || rx_n !== 2) begin
            errors++;
            $display("FAIL stop_count: got acks=%0d bytes=%0d want 2 2", rd_ack_cnt - a0, rx_n);
        end
        rd_n = 0;
    endtask

    task automatic test_busy;
        bit ok; logic [7:0] ist, est, want; int o0, a0;
`ifdef CU_SHORT_BUSY_EN
        want = 8'h50;
`else
        want = 8'h10;
`endif
        for (int i = 0; i < 4; i++) rd_mem[i] = 8'($urandom);
        rd_base = rd_ack_cnt; rd_n = 4; o0 = op_cnt; a0 = rd_ack_cnt;
        dev_busy = 1'b1;
        run_sel(8'h1a, 8'h02, 4, -1, -1, ok, ist, est);
        dev_busy = 1'b0;
        checks++;
        if ({ok, ist} !== {1'b1, want} || (rd_ack_cnt - a0) !== 0) begin
            errors++;
            $display("FAIL busy_status: got ok=%b init=%h acks=%0d want 1 %h 0", ok, ist, rd_ack_cnt - a0, want);
        end
`ifdef CU_SHORT_BUSY_EN
        checks++;
        if ((op_cnt - o0) !== 0) begin
            errors++;
            $display("FAIL busy_short_op: got op_cycles=%0d want 0", op_cnt - o0);
        end
`endif
        rd_n = 0;
    endtask

    task automatic test_commands;
        bit ok; logic [7:0] ist, est, code;
        logic [7:0] codes [0:2];
        logic [7:0] wants [0:2];
        code = 8'($urandom);
        while (code >= 8'h01 && code <= 8'h03) code = 8'($urandom);
        codes[0] = 8'hff; wants[0] = 8'h0e;
        codes[1] = 8'h03; wants[1] = 8'h0c;
        codes[2] = code;  wants[2] = 8'h0e;
        for (int i = 0; i < 3; i++) begin
            run_sel(8'h1a, codes[i], 2, -1, -1, ok, ist, est);
            checks++;
            if ({ok, ist, cmd} !== {1'b1, wants[i], codes[i]}) begin
                errors++;
                $display("FAIL cmd_%h: got ok=%b init=%h cmd=%h want 1 %h %h", codes[i], ok, ist, cmd,
                         wants[i], codes[i]);
            end
        end
    endtask

    task automatic test_selective_reset;
        bit ok; logic [7:0] ist, est; int a0;
        for (int i = 0; i < 8; i++) rd_mem[i] = 8'($urandom);
        rd_base = rd_ack_cnt; rd_n = 8; a0 = rd_ack_cnt; abort_tags = 4'hf;
        run_sel(8'h1a, 8'h02, 8, -1, 2, ok, ist, est);
        checks++;
        if ({ok, abort_tags} !== {1'b1, 4'h0}) begin
            errors++;
            $display("FAIL selreset_tags: got ok=%b tags=%b want 1 0000", ok, abort_tags);
        end
        checks++;
        if ((rd_ack_cnt - a0) !== 2) begin
            errors++;
            $display("FAIL selreset_acks: got %0d want 2", rd_ack_cnt - a0);
        end
        rd_n = 0;
        run_sel(8'h1a, 8'h03, 2, -1, -1, ok, ist, est);
        checks++;
        if ({ok, echo, ist} !== {1'b1, 8'h1a, 8'h0c}) begin
            errors++;
            $display("FAIL selreset_idle: got ok=%b echo=%h init=%h want 1 1a 0c", ok, echo, ist);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pass();
        test_read();
        test_write();
        test_stop();
        test_busy();
        test_commands();
        test_selective_reset();
        test_pass();
        test_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
